mdu_iter32: RTL and testbench

Iterative 32-bit multiply/divide unit for the processor's execute stage. Accepts a start pulse with two 32-bit operands and an operation code. Produces a 64-bit product, or a quotient/remainder pair, in HI/LO registers after a fixed latency. HI and LO drive two inputs of the 8:1 32-bit writeback result mux, and the control unit stalls the PC while `busy` is high.

---
 rtl/mdu_iter32.sv | 159 +++++++++++++++
 tb/tb_mdu_iter32.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mdu_iter32.sv
// mdu_iter32: iterative 32-bit multiply/divide unit.
// Shift-add multiply and restoring divide share one 64-bit accumulator.
// Signed ops work on magnitudes; the sign fix is applied in a final SIGN cycle.
// Results land in hi/lo 33 cycles after the accepted start and hold until the next result.
//
// Handshake: start is a one-cycle request, accepted only in IDLE or DONE and ignored otherwise.
// done pulses for one cycle when hi/lo become valid. busy is high while an operation is in flight.
module mdu_iter32 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;     // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]     opnd_q, opnd_d;   // multiplicand magnitude or divisor magnitude
    logic [XLEN-1:0]     a_orig_q, a_orig_d;
    logic                is_div_q, is_div_d;
    logic                div0_q, div0_d;
    logic                neg_q_q, neg_q_d; // negate product / quotient
    logic                neg_r_q, neg_r_d; // negate remainder
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;

    // Operand magnitudes; negating 0x80000000 yields 0x80000000, which is the desired magnitude.
    logic                sgn_op;
    logic [XLEN-1:0]     a_mag, b_mag;
    assign sgn_op = ~op[0];
    assign a_mag  = (sgn_op && a[XLEN-1]) ? (~a + 1'b1) : a;
    assign b_mag  = (sgn_op && b[XLEN-1]) ? (~b + 1'b1) : b;

    // One multiply step: add the multiplicand when the current multiplier bit is set, then shift right.
    logic [XLEN:0]       add_sum;
    assign add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});

    // One restoring-divide step: shift the next dividend bit into the remainder, trial-subtract.
    logic [XLEN:0]       rem_sh, rem_sub;
    logic                rem_ge;
    assign rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign rem_sub = rem_sh - {1'b0, opnd_q};
    assign rem_ge  = (rem_sh >= {1'b0, opnd_q});

    // Signed result fix-ups used in the SIGN cycle.
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix;
    assign prod_fix = neg_q_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = neg_q_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    assign rem_fix  = neg_r_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

    // State register and all datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_orig_q <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_orig_q <= a_orig_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Next-state and datapath update: latch on start, iterate in CALC, fix signs and publish in SIGN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_orig_d = a_orig_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    div0_d   = op[1] && (b == '0);
                    neg_q_d  = sgn_op && (a[XLEN-1] ^ b[XLEN-1]);
                    neg_r_d  = sgn_op && a[XLEN-1];
                    a_orig_d = a;
                    opnd_d   = op[1] ? b_mag : a_mag;
                    acc_d    = {{XLEN{1'b0}}, (op[1] ? a_mag : b_mag)};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (is_div_q) begin
                    if (rem_ge) acc_d = {rem_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else        acc_d = {rem_sh[XLEN-1:0],  acc_q[XLEN-2:0], 1'b0};
                end else begin
                    acc_d = {add_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == 5'd31) state_d = S_SIGN;
            end
            S_SIGN: begin
                state_d = S_DONE;
                if (div0_q) begin
                    hi_d = a_orig_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_CALC) || (state_q == S_SIGN);
    assign done      = (state_q == S_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_iter32.sv
// Testbench for mdu_iter32: directed vectors, scoreboard queue checked by an independent monitor.
module tb_mdu_iter32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  mdu_iter32 #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {hi, lo}
  int          exp_cyc_q[$];
  int          total = 0;
  int          bad = 0;
  int          busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples 1ns after each rising edge, pops an expectation on every done.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          logic [63:0] e;
          int          ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("hi", {32'd0, hi}, {32'd0, e[63:32]});
          check("lo", {32'd0, lo}, {32'd0, e[31:0]});
          check("latency", 64'(cyc), 64'(ec));
          check("busy_cycles", 64'(busy_cnt), 64'd33);
          check("busy_in_done", {63'd0, busy}, 64'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks (called aligned to a falling edge) ----------------
  task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] ehi, input logic [31:0] elo);
    start = 1'b1; op = o; a = va; b = vb;
    exp_q.push_back({ehi, elo});
    exp_cyc_q.push_back(cyc + 1 + 33);
    @(negedge clk);
    start = 1'b0; a = $urandom(); b = $urandom();
  endtask

  task automatic pulse_only(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_wait_result", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_wait_done", {63'd0, done}, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001); wait_idle();
    issue(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB); wait_idle();
    issue(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000); wait_idle();
    issue(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD); wait_idle();
    issue(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD); wait_idle();
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000); wait_idle();
    issue(OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF); wait_idle();
    issue(OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF); wait_idle();

    // Ignored start during CALC, then back-to-back start in the DONE cycle.
    issue(OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142);
    repeat (9) @(negedge clk);
    pulse_only(OP_DIVU, 32'd50, 32'd5);
    wait_done();
    issue(OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
    repeat (10) @(negedge clk);
    check("hold_hi", {32'd0, hi}, 64'd6);
    check("hold_lo", {32'd0, lo}, 64'd142);
    check("busy_mid", {63'd0, busy}, 64'd1);
    wait_idle();

    // Reset in flight discards the operation.
    issue(OP_MULTU, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 32'hFFFE0001);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2); wait_idle();

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
